alu4_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/alu_rr_pick.sv | 36 +++
 rtl/alu4_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu4_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU-slice arbiter: datapath widths, op-select
// bit positions, the arbiter state encoding and slice-offset helpers.
package alu_arb_pkg;

  localparam int DATA_W = 4;   // ALU operand/result width
  localparam int SEL_W  = 3;   // op select {m,s1,s0}

  // Bit positions inside one op-select slice
  localparam int SEL_M  = 2;
  localparam int SEL_S1 = 1;
  localparam int SEL_S0 = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // LSB of requester i's operand slice inside a flattened operand bus
  function automatic int data_lsb(input int i);
    return i * DATA_W;
  endfunction

  // LSB of requester i's op-select slice inside the flattened select bus
  function automatic int sel_lsb(input int i);
    return i * SEL_W;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker. Starting just after rr_ptr and wrapping
// modulo NREQ, the first asserted request wins. Outputs the winner one-hot
// and as an index; both are zero when no request is asserted.
module alu_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx
);

  int   cand;
  logic found;

  // Scan candidates in priority order rr_ptr+1, rr_ptr+2, ... (mod NREQ)
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req[IDX_W'(cand)]) begin
        found                  = 1'b1;
        win_oh[IDX_W'(cand)]   = 1'b1;
        win_idx                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU slice among NREQ
// requesters. The winner's operands are latched onto the ALU inputs, held
// for SETTLE cycles, then the ALU result is captured and returned with a
// one-cycle rsp_valid pulse to the winner.
//
// Handshake: a requester raises req (level) with stable operands; the
// arbiter answers with a one-cycle gnt pulse, at which point the operands
// are latched and req should drop. One SETTLE+2 cycle transaction at a time;
// req is ignored outside IDLE.
//
// Optional feature macro ALU_ARB_STATS_EN: adds stat_clr / stat_cnt ports
// and per-requester saturating grant counters of width CNT_W.
module alu4_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SETTLE = 1
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [DATA_W*NREQ-1:0]   op_a,
  input  logic [DATA_W*NREQ-1:0]   op_b,
  input  logic [SEL_W*NREQ-1:0]    op_sel,
`ifdef ALU_ARB_STATS_EN
  input  logic                     stat_clr,
  output logic [CNT_W*NREQ-1:0]    stat_cnt,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_f,
  output logic                     rsp_cout,
  output logic                     busy,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic                     alu_m,
  output logic                     alu_s1,
  output logic                     alu_s0,
  input  logic [DATA_W-1:0]        alu_f,
  input  logic                     alu_cout,
  output logic [1:0]               dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  arb_state_t        state, state_nxt;
  logic [SC_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NREQ-1:0]   rsp_nxt;
  logic              load;
  logic              capture;

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [SEL_W-1:0]  opnd_sel;

  // Per-requester views of the flattened operand buses
  logic [DATA_W-1:0] a_sl   [NREQ];
  logic [DATA_W-1:0] b_sl   [NREQ];
  logic [SEL_W-1:0]  sel_sl [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_sl[i]   = op_a[data_lsb(i) +: DATA_W];
    assign b_sl[i]   = op_b[data_lsb(i) +: DATA_W];
    assign sel_sl[i] = op_sel[sel_lsb(i) +: SEL_W];
  end

  alu_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, settle countdown and next values of the pulse outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    rsp_nxt   = '0;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load      = 1'b1;
          gnt_nxt   = win_oh;
          cnt_nxt   = SC_W'(SETTLE - 1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          rsp_nxt   = NREQ'(1) << rr_ptr;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - SC_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: operand latch, round-robin pointer, pulses, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_a    <= '0;
      opnd_b    <= '0;
      opnd_sel  <= '0;
      rr_ptr    <= IDX_W'(NREQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_f     <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      rsp_valid <= rsp_nxt;
      if (load) begin
        opnd_a   <= a_sl[win_idx];
        opnd_b   <= b_sl[win_idx];
        opnd_sel <= sel_sl[win_idx];
        rr_ptr   <= win_idx;
      end
      if (capture) begin
        rsp_f    <= alu_f;
        rsp_cout <= alu_cout;
      end
    end
  end

  // ALU inputs come straight from the operand latch, so they only move at a grant
  assign alu_a     = opnd_a;
  assign alu_b     = opnd_b;
  assign alu_m     = opnd_sel[SEL_M];
  assign alu_s1    = opnd_sel[SEL_S1];
  assign alu_s0    = opnd_sel[SEL_S0];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] stat_q [NREQ];

  // Saturating per-requester grant counters; a clear beats a same-cycle grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          stat_q[i] <= '0;
        end else if (gnt[i] && (stat_q[i] != {CNT_W{1'b1}})) begin
          stat_q[i] <= stat_q[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat_out
    assign stat_cnt[i*CNT_W +: CNT_W] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_alu4_arbiter.sv
// Bench for alu4_arbiter. Two instances share one set of requesters: dut0
// with SETTLE=1 and dut1 with SETTLE=3, each with its own reset and its own
// stub ALU (f = a+b, cout = carry). A transaction-level model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_alu4_arbiter;
  import alu_arb_pkg::*;

  localparam int NR = 2;
  localparam int ND = 2;
  localparam int S0 = 1;
  localparam int S1 = 3;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic [ND-1:0] rst;
  always #5 clk = ~clk;

  // ---------------- stimulus and DUT wiring ----------------
  logic [NR-1:0]   req;
  logic [4*NR-1:0] op_a, op_b;
  logic [3*NR-1:0] op_sel;

  logic [NR-1:0] d_gnt [ND];
  logic [NR-1:0] d_rsp [ND];
  logic [3:0]    d_f   [ND];
  logic          d_cout[ND];
  logic          d_busy[ND];
  logic [3:0]    d_a   [ND];
  logic [3:0]    d_b   [ND];
  logic          d_m   [ND];
  logic          d_s1  [ND];
  logic          d_s0  [ND];
  logic [3:0]    s_f   [ND];
  logic          s_cout[ND];
  logic [1:0]    d_dbg [ND];
`ifdef ALU_ARB_STATS_EN
  logic           stat_clr;
  logic [CW*NR-1:0] d_stat [ND];
`endif

  alu4_arbiter #(
    .NREQ(NR), .SETTLE(S0)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
`ifdef ALU_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cnt(d_stat[0]),
`endif
    .gnt(d_gnt[0]), .rsp_valid(d_rsp[0]), .rsp_f(d_f[0]), .rsp_cout(d_cout[0]),
    .busy(d_busy[0]), .alu_a(d_a[0]), .alu_b(d_b[0]), .alu_m(d_m[0]),
    .alu_s1(d_s1[0]), .alu_s0(d_s0[0]), .alu_f(s_f[0]), .alu_cout(s_cout[0]),
    .dbg_state(d_dbg[0])
  );

  alu4_arbiter #(
    .NREQ(NR), .SETTLE(S1)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(CW)
`endif
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
`ifdef ALU_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_cnt(d_stat[1]),
`endif
    .gnt(d_gnt[1]), .rsp_valid(d_rsp[1]), .rsp_f(d_f[1]), .rsp_cout(d_cout[1]),
    .busy(d_busy[1]), .alu_a(d_a[1]), .alu_b(d_b[1]), .alu_m(d_m[1]),
    .alu_s1(d_s1[1]), .alu_s0(d_s0[1]), .alu_f(s_f[1]), .alu_cout(s_cout[1]),
    .dbg_state(d_dbg[1])
  );

  // Stub ALUs: 4-bit add with carry-out, op select ignored
  for (genvar k = 0; k < ND; k++) begin : g_stub
    assign {s_cout[k], s_f[k]} = 5'(d_a[k]) + 5'(d_b[k]);
  end

  // ---------------- counters and check helper ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a grant at edge g owns the block until edge g+SETTLE+1;
  // gnt is seen after g, rsp after g+SETTLE, the next grant no earlier than
  // g+SETTLE+2. The winner is the first requester after the previous winner.
  int          cyc = 0;
  int          settle_of [ND] = '{S0, S1};
  bit          act_m  [ND];
  int          g_edge [ND];
  int          last_w [ND];
  logic [NR-1:0] e_gnt [ND];
  logic [NR-1:0] e_rsp [ND];
  logic          e_busy[ND];
  logic [3:0]    e_a   [ND];
  logic [3:0]    e_b   [ND];
  logic [2:0]    e_sel [ND];
  logic [4:0]    exp_q [ND][$];
  logic [4:0]    last_res [ND];
  bit            chk_on = 1'b0;
  int            gnt_log [$];
`ifdef ALU_ARB_STATS_EN
  int            e_stat [ND][NR];
`endif

  always @(posedge clk) begin
    int w, c, s;
    cyc++;
    for (int k = 0; k < ND; k++) begin
      if (rst[k]) begin
        act_m[k]  = 1'b0;
        g_edge[k] = 0;
        last_w[k] = NR - 1;
        e_gnt[k]  = '0;
        e_rsp[k]  = '0;
        e_busy[k] = 1'b0;
        e_a[k]    = '0;
        e_b[k]    = '0;
        e_sel[k]  = '0;
        last_res[k] = '0;
        exp_q[k].delete();
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < NR; i++) e_stat[k][i] = 0;
`endif
      end else begin
`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < NR; i++) begin
          if (stat_clr) e_stat[k][i] = 0;
          else if (((e_gnt[k] >> i) & 1) != 0 && e_stat[k][i] < (1 << CW) - 1)
            e_stat[k][i] = e_stat[k][i] + 1;
        end
`endif
        e_gnt[k] = '0;
        e_rsp[k] = '0;
        if (act_m[k] && cyc == g_edge[k] + settle_of[k])
          e_rsp[k] = NR'(1) << last_w[k];
        if ((!act_m[k] || cyc >= g_edge[k] + settle_of[k] + 2) && req != '0) begin
          w = -1;
          for (int j = 1; j <= NR; j++) begin
            c = (last_w[k] + j) % NR;
            if (w < 0 && ((req >> c) & 1) != 0) w = c;
          end
          last_w[k] = w;
          g_edge[k] = cyc;
          act_m[k]  = 1'b1;
          e_gnt[k]  = NR'(1) << w;
          e_a[k]    = op_a[4*w +: 4];
          e_b[k]    = op_b[4*w +: 4];
          e_sel[k]  = op_sel[3*w +: 3];
          s = int'(e_a[k]) + int'(e_b[k]);
          exp_q[k].push_back(5'(s));
        end
        e_busy[k] = act_m[k] && (cyc <= g_edge[k] + settle_of[k]);
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < ND; k++) begin
        if (!rst[k]) begin
          check("gnt", k, 32'(d_gnt[k]), 32'(e_gnt[k]));
          check("rsp_valid", k, 32'(d_rsp[k]), 32'(e_rsp[k]));
          check("busy", k, 32'(d_busy[k]), 32'(e_busy[k]));
          check("alu_a", k, 32'(d_a[k]), 32'(e_a[k]));
          check("alu_b", k, 32'(d_b[k]), 32'(e_b[k]));
          check("alu_sel", k, 32'({d_m[k], d_s1[k], d_s0[k]}), 32'(e_sel[k]));
          if (d_rsp[k] != '0) begin
            if (exp_q[k].size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL rsp_q dut%0d got=rsp_valid %0h want=no pending result t=%0t",
                       k, d_rsp[k], $time);
            end else begin
              last_res[k] = exp_q[k].pop_front();
            end
          end
          check("rsp_result", k, 32'({d_cout[k], d_f[k]}), 32'(last_res[k]));
          if (!e_busy[k]) check("dbg_idle", k, 32'(d_dbg[k]), 32'(IDLE));
`ifdef ALU_ARB_STATS_EN
          for (int i = 0; i < NR; i++)
            check("stat_cnt", k, 32'(d_stat[k][i*CW +: CW]), 32'(e_stat[k][i]));
`endif
          if (k == 0 && d_gnt[0] != '0) gnt_log.push_back(int'(d_gnt[0][1]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!d_busy[0] && !d_busy[1]) return;
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle dut0/dut1 got=busy want=idle within 60 cycles t=%0t", $time);
  endtask

  task automatic check_zero(input int k);
    check("z_gnt", k, 32'(d_gnt[k]), 32'd0);
    check("z_rsp_valid", k, 32'(d_rsp[k]), 32'd0);
    check("z_rsp_f", k, 32'(d_f[k]), 32'd0);
    check("z_rsp_cout", k, 32'(d_cout[k]), 32'd0);
    check("z_busy", k, 32'(d_busy[k]), 32'd0);
    check("z_alu_a", k, 32'(d_a[k]), 32'd0);
    check("z_alu_b", k, 32'(d_b[k]), 32'd0);
    check("z_alu_sel", k, 32'({d_m[k], d_s1[k], d_s0[k]}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = '1;
    req    = '0;
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst    = '0;
    chk_on = 1'b1;

    // 1: single request, SETTLE=1 timing on dut0
    req = 2'b01; op_a[3:0] = 4'b0101; op_b[3:0] = 4'b0100; op_sel[2:0] = 3'b000;
    @(negedge clk);
    check("s1_gnt", 0, 32'(d_gnt[0]), 32'h1);
    check("s1_busy0", 0, 32'(d_busy[0]), 32'h1);
    check("s1_alu_a", 0, 32'(d_a[0]), 32'h5);
    req = '0;
    @(negedge clk);
    check("s1_rsp", 0, 32'(d_rsp[0]), 32'h1);
    check("s1_f", 0, 32'(d_f[0]), 32'h9);
    check("s1_cout", 0, 32'(d_cout[0]), 32'h0);
    check("s1_busy1", 0, 32'(d_busy[0]), 32'h1);
    @(negedge clk);
    check("s1_busy2", 0, 32'(d_busy[0]), 32'h0);
    check("s1_f_hold", 0, 32'(d_f[0]), 32'h9);
    wait_idle();

    // 2: carry case from requester 1, op select mirrored on the ALU pins
    req = 2'b10; op_a[7:4] = 4'b1010; op_b[7:4] = 4'b0111; op_sel[5:3] = 3'b101;
    @(negedge clk);
    check("s2_gnt", 0, 32'(d_gnt[0]), 32'h2);
    check("s2_sel", 0, 32'({d_m[0], d_s1[0], d_s0[0]}), 32'h5);
    req = '0;
    @(negedge clk);
    check("s2_rsp", 0, 32'(d_rsp[0]), 32'h2);
    check("s2_f", 0, 32'(d_f[0]), 32'h1);
    check("s2_cout", 0, 32'(d_cout[0]), 32'h1);
    wait_idle();

    // 3: permanent contention, grants alternate starting with requester 0
    gnt_log.delete();
    req = 2'b11; op_a = 8'h3c; op_b = 8'h5a; op_sel = 6'o25;
    repeat (12) @(negedge clk);
    req = '0;
    check("s3_ngrants", 0, 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++)
      check("s3_order", 0, 32'(gnt_log[i]), 32'(i % 2));
    wait_idle();

    // 4: operands change after the grant; latched values are used
    req = 2'b01; op_a[3:0] = 4'b0101; op_b[3:0] = 4'b0100; op_sel[2:0] = 3'b010;
    @(negedge clk);
    op_a[3:0] = 4'b1111;
    req = '0;
    @(negedge clk);
    check("s4_rsp", 0, 32'(d_rsp[0]), 32'h1);
    check("s4_f", 0, 32'(d_f[0]), 32'h9);
    wait_idle();

    // 5: reset dut1 (SETTLE=3) in its second EXEC cycle
    req = 2'b01; op_a[3:0] = 4'b0011; op_b[3:0] = 4'b0001;
    @(negedge clk);
    check("s5_gnt", 1, 32'(d_gnt[1]), 32'h1);
    req = '0;
    @(negedge clk);
    check("s5_busy", 1, 32'(d_busy[1]), 32'h1);
    rst[1] = 1'b1;
    #1;
    check_zero(1);
    @(negedge clk);
    rst[1] = 1'b0;
    wait_idle();
    req = 2'b11;
    @(negedge clk);
    check("s5_regnt", 1, 32'(d_gnt[1]), 32'h1);
    req = '0;
    wait_idle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst    = '0;
      req    = NR'($urandom_range(0, 3));
      op_a   = 8'($urandom);
      op_b   = 8'($urandom);
      op_sel = 6'($urandom);
      if ($urandom_range(0, 99) == 0) rst[$urandom_range(0, 1)] = 1'b1;
    end
    @(negedge clk);
    rst = '0;
    req = '0;
    wait_idle();

`ifdef ALU_ARB_STATS_EN
    // 6: grant counter saturation and clear
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    gnt_log.delete();
    req = 2'b01;
    for (int i = 0; i < 40 && gnt_log.size() < 5; i++) @(negedge clk);
    req = '0;
    @(negedge clk);
    check("s6_sat", 0, 32'(d_stat[0][1:0]), 32'd3);
    check("s6_other", 0, 32'(d_stat[0][3:2]), 32'd0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check("s6_clr", 0, 32'(d_stat[0][1:0]), 32'd0);
    wait_idle();
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
